// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
//
// Two-requester arbiter and sequencer in front of a single-port 16 x 32-bit
// register file. Only one command is accepted at a time, so the register
// file never sees read_en and write_en in the same cycle.
//
// Sequence per command: IDLE (arbitrate, gnt pulse) -> ISSUE (one strobe to
// the register file) -> RESP (reads only: rvalid pulse to the owner).
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   a_req/a_we/a_addr/a_wdata   requester A command (held until a_gnt)
//   a_gnt                       A command accepted, one-cycle pulse
//   a_rvalid/a_rdata            A read response, one-cycle pulse
//   b_*                         same set for requester B
//   rf_read_en/rf_write_en      register file strobes (ISSUE cycle only)
//   rf_addr/rf_write_data       register file address / write data (held)
//   rf_read_data                register file read data, valid the cycle
//                               after rf_read_en
//
// Configuration
//   REG_ARB_FIXED_PRIO_EN  defined: A always wins contention (B may starve).
//                          undefined (default): round-robin arbitration.
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,

   output logic              rf_read_en,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [DATA_W-1:0] rf_read_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Latched command attributes needed after the grant. The address and
   // write data are captured directly into rf_addr / rf_write_data, which
   // already hold their value outside ISSUE.
   logic lat_we;
   logic lat_owner;            // 0 = A, 1 = B

   logic              accept;
   logic              win_b;   // 1 = B wins this IDLE cycle
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef REG_ARB_FIXED_PRIO_EN
   // B only wins when A is not asking.
   always_comb begin
      win_b = b_req & ~a_req;
   end
`else
   logic last_owner;           // 0 = A, 1 = B; reset to B so A wins first

   // A lone requester wins; under contention the one that did not own the
   // previous command wins.
   always_comb begin
      win_b = b_req & (~a_req | ~last_owner);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= 1'b1;
      end else if (accept) begin
         last_owner <= win_b;
      end
   end
`endif

   // NOTE: every signal assigned in an always_comb gets a value on every
   // path (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      accept    = (state == IDLE) && (a_req || b_req);
      cmd_we    = win_b ? b_we    : a_we;
      cmd_addr  = win_b ? b_addr  : a_addr;
      cmd_wdata = win_b ? b_wdata : a_wdata;
      // Grants are combinational; gating by rst_n keeps them low while the
      // block is held in reset even if requests are pending.
      a_gnt     = accept && !win_b && rst_n;
      b_gnt     = accept &&  win_b && rst_n;
   end

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = lat_we ? IDLE : RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch and register file drive
   // ------------------------------------------------------------------
   // The strobes are loaded on the accepting edge so they are high exactly
   // during ISSUE, and cleared on every other edge. Reset clears them
   // asynchronously, which aborts an in-flight write before it lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we        <= 1'b0;
         lat_owner     <= 1'b0;
         rf_read_en    <= 1'b0;
         rf_write_en   <= 1'b0;
         rf_addr       <= '0;
         rf_write_data <= '0;
      end else if (accept) begin
         lat_we      <= cmd_we;
         lat_owner   <= win_b;
         rf_read_en  <= ~cmd_we;
         rf_write_en <= cmd_we;
         rf_addr     <= cmd_addr;
         if (cmd_we) begin
            rf_write_data <= cmd_wdata;
         end
      end else begin
         rf_read_en  <= 1'b0;
         rf_write_en <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Read response: register file output is valid during RESP
   // ------------------------------------------------------------------
   always_comb begin
      a_rvalid = (state == RESP) && !lat_owner;
      b_rvalid = (state == RESP) &&  lat_owner;
      a_rdata  = a_rvalid ? rf_read_data : '0;
      b_rdata  = b_rvalid ? rf_read_data : '0;
   end

   // The single-port register file must never see both strobes.
   rf_strobe_exclusive : assert property (
      @(posedge clk) disable iff (!rst_n) !(rf_read_en && rf_write_en)
   );

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          rf_read_en, rf_write_en;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_write_data;
   logic [DW-1:0] rf_read_data = '0;

   always #5 clk = ~clk;

   reg_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_addr(rf_addr), .rf_write_data(rf_write_data),
      .rf_read_data(rf_read_data)
   );

   // Register file stand-in: single port, registered read data.
   logic [DW-1:0] rf_mem [16] = '{default: '0};
   always @(posedge clk) begin
      if (rf_write_en) rf_mem[rf_addr] <= rf_write_data;
      if (rf_read_en)  rf_read_data    <= rf_mem[rf_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Transaction-level reference: a grant schedules one register file
   // strobe for the next cycle and, for reads, a response the cycle after.
   // ------------------------------------------------------------------
   typedef struct {
      bit          rd, wr, own_b, rv_a, rv_b;
      logic [3:0]  addr;
      logic [31:0] wdata, rdata;
   } slot_t;

   slot_t       slot0, slot1;      // expectations for this / next cycle
   bit          m_last_b;
   int          m_busy;            // cycles before the next grant is possible
   logic [3:0]  m_rf_addr;
   logic [31:0] m_rf_wdata;
   logic [31:0] ref_mem [16] = '{default: '0};

   bit          cap_a_gnt, cap_b_gnt, cap_a_rv, cap_b_rv, cap_rd, cap_wr;
   logic [31:0] cap_a_rdata, cap_b_rdata, cap_wdata;
   logic [3:0]  cap_addr;

   task automatic model_reset();
      slot0      = '{default: '0};
      slot1      = '{default: '0};
      m_last_b   = 1'b1;
      m_busy     = 0;
      m_rf_addr  = '0;
      m_rf_wdata = '0;
   endtask

   // Runs at the falling edge: predict this cycle, compare, advance.
   task automatic step();
      bit e_ga, e_gb, wb;
      cap_a_gnt = a_gnt;  cap_b_gnt = b_gnt;
      cap_a_rv = a_rvalid; cap_b_rv = b_rvalid;
      cap_a_rdata = a_rdata; cap_b_rdata = b_rdata;
      cap_rd = rf_read_en; cap_wr = rf_write_en;
      cap_addr = rf_addr; cap_wdata = rf_write_data;
      e_ga = 1'b0; e_gb = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (slot0.wr) begin
            m_rf_addr = slot0.addr; m_rf_wdata = slot0.wdata;
            ref_mem[slot0.addr] = slot0.wdata;
         end
         if (slot0.rd) begin
            m_rf_addr   = slot0.addr;
            slot1.rv_a  = !slot0.own_b;
            slot1.rv_b  = slot0.own_b;
            slot1.rdata = ref_mem[slot0.addr];
         end
         if (m_busy > 0) begin
            m_busy--;
         end else if (a_req || b_req) begin
`ifdef REG_ARB_FIXED_PRIO_EN
            wb = !a_req;
`else
            wb = a_req && b_req ? !m_last_b : b_req;
`endif
            e_ga = !wb; e_gb = wb; m_last_b = wb;
            slot1.own_b = wb;
            slot1.wr    = wb ? b_we : a_we;
            slot1.rd    = !slot1.wr;
            slot1.addr  = wb ? b_addr : a_addr;
            slot1.wdata = wb ? b_wdata : a_wdata;
            m_busy      = slot1.wr ? 1 : 2;
         end
      end
      check("a_gnt", cap_a_gnt, e_ga);
      check("b_gnt", cap_b_gnt, e_gb);
      check("rf_read_en", cap_rd, slot0.rd);
      check("rf_write_en", cap_wr, slot0.wr);
      check("rf_addr", cap_addr, m_rf_addr);
      check("rf_write_data", cap_wdata, m_rf_wdata);
      check("a_rvalid", cap_a_rv, slot0.rv_a);
      check("b_rvalid", cap_b_rv, slot0.rv_b);
      check("a_rdata", cap_a_rdata, slot0.rv_a ? slot0.rdata : 32'h0);
      check("b_rdata", cap_b_rdata, slot0.rv_b ? slot0.rdata : 32'h0);
      check("rf_strobe_excl", cap_rd & cap_wr, 1'b0);
      slot0 = slot1;
      slot1 = '{default: '0};
   endtask

   // Inputs are driven at posedge+1; outputs are compared at the negedge.
   task automatic cycle();
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic rnd_port(input bit granted, inout logic req, inout logic we,
                           inout logic [3:0] addr, inout logic [31:0] wdata);
      bit withdrew;
      withdrew = 1'b0;
      if (req && granted) begin
         req = 1'b0;
      end else if (req && $urandom_range(15) == 0) begin
         req = 1'b0; withdrew = 1'b1;
      end
      if (!req && !withdrew && $urandom_range(1) == 1) begin
         req   = 1'b1;
         we    = 1'($urandom_range(1));
         addr  = 4'($urandom_range(15));
         wdata = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   bit          gq_b [$];
   int          gq_c [$];
   logic [31:0] rva [$];
   logic [31:0] rvb [$];
   int          na, nb;

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #1;
      cycle();
      cycle();
      check("rst_a_gnt", cap_a_gnt, 0);
      check("rst_rf_strobes", {cap_rd, cap_wr}, 0);
      check("rst_rf_addr", cap_addr, 0);
      check("rst_rf_wdata", cap_wdata, 0);
      rst_n = 1'b1;
      cycle();

      // ---- single write by A, then read-back by B ----
      a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 32'hDEADBEEF;
      cycle();
      check("t1_a_gnt", cap_a_gnt, 1);
      a_req = 0;
      cycle();
      check("t1_wr_en", cap_wr, 1);
      check("t1_rd_en", cap_rd, 0);
      check("t1_addr", cap_addr, 3);
      check("t1_wdata", cap_wdata, 32'hDEADBEEF);
      b_req = 1; b_we = 0; b_addr = 4'd3;
      cycle();
      check("t1_b_gnt", cap_b_gnt, 1);
      b_req = 0;
      cycle();
      cycle();
      check("t1_b_rvalid", cap_b_rv, 1);
      check("t1_b_rdata", cap_b_rdata, 32'hDEADBEEF);
      check("t1_a_rvalid", cap_a_rv, 0);

      // ---- preload addr 1 (A) and addr 2 (B); last owner becomes B ----
      a_req = 1; a_we = 1; a_addr = 4'd1; a_wdata = 32'h11111111;
      cycle(); a_req = 0; cycle();
      b_req = 1; b_we = 1; b_addr = 4'd2; b_wdata = 32'h22222222;
      cycle(); b_req = 0; cycle();

      // ---- read contention: A, B, A, B every 3 cycles ----
      a_req = 1; a_we = 0; a_addr = 4'd1;
      b_req = 1; b_we = 0; b_addr = 4'd2;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (cap_a_gnt) begin gq_b.push_back(1'b0); gq_c.push_back(i); end
         if (cap_b_gnt) begin gq_b.push_back(1'b1); gq_c.push_back(i); end
         if (cap_a_rv) rva.push_back(cap_a_rdata);
         if (cap_b_rv) rvb.push_back(cap_b_rdata);
      end
      idle_inputs();
      check("cont_gnt_count", gq_b.size(), 4);
      check("cont_rva_count", rva.size(), 2);
      check("cont_rvb_count", rvb.size(), 2);
      for (int i = 0; i < gq_b.size() && i < 4; i++) begin
         check($sformatf("cont_owner%0d", i), gq_b[i], (i % 2 == 1));
         check($sformatf("cont_cycle%0d", i), gq_c[i], 3 * i);
      end
      foreach (rva[i]) check("cont_rdata_a", rva[i], 32'h11111111);
      foreach (rvb[i]) check("cont_rdata_b", rvb[i], 32'h22222222);

      // ---- mixed: A writes addr 5 while B reads addr 5 ----
      a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 32'h12345678;
      b_req = 1; b_we = 0; b_addr = 4'd5;
      cycle();
      check("mix_a_gnt", cap_a_gnt, 1);
      check("mix_b_gnt", cap_b_gnt, 0);
      a_req = 0;
      cycle();
      cycle();
      check("mix_b_gnt2", cap_b_gnt, 1);
      b_req = 0;
      cycle();
      cycle();
      check("mix_b_rvalid", cap_b_rv, 1);
      check("mix_b_rdata", cap_b_rdata, 32'h12345678);

      // ---- random traffic ----
      for (int i = 0; i < 200; i++) begin
         rnd_port(cap_a_gnt, a_req, a_we, a_addr, a_wdata);
         rnd_port(cap_b_gnt, b_req, b_we, b_addr, b_wdata);
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) cycle();
      for (int i = 0; i < 16; i++)
         check($sformatf("mem[%0d]", i), rf_mem[i], ref_mem[i]);

      // ---- reset during the ISSUE cycle of a read ----
      a_req = 1; a_we = 0; a_addr = 4'd1;
      cycle();
      check("mr_a_gnt", cap_a_gnt, 1);
      a_req = 0;
      check("mr_issue_rd", rf_read_en, 1);
      rst_n = 1'b0;
      #1;
      check("mr_rd_cleared", rf_read_en, 0);
      check("mr_addr_cleared", rf_addr, 0);
      check("mr_a_rvalid_now", a_rvalid, 0);
      cycle();
      check("mr_no_rvalid", cap_a_rv | cap_b_rv, 0);
      rst_n = 1'b1;
      a_req = 1; a_we = 0; a_addr = 4'd2;
      b_req = 1; b_we = 0; b_addr = 4'd1;
      cycle();
      check("mr_first_a", cap_a_gnt, 1);
      check("mr_first_b", cap_b_gnt, 0);
      for (int i = 0; i < 6; i++) cycle();
      idle_inputs();
      for (int i = 0; i < 4; i++) cycle();

`ifdef REG_ARB_FIXED_PRIO_EN
      // ---- fixed priority: A starves B until A drops ----
      na = 0; nb = 0;
      a_req = 1; a_we = 0; a_addr = 4'd3;
      b_req = 1; b_we = 0; b_addr = 4'd5;
      for (int i = 0; i < 9; i++) begin
         cycle();
         na += int'(cap_a_gnt); nb += int'(cap_b_gnt);
      end
      check("fp_a_grants", na, 3);
      check("fp_b_grants", nb, 0);
      a_req = 0;
      cycle();
      check("fp_b_after_drop", cap_b_gnt, 1);
      b_req = 0;
      for (int i = 0; i < 4; i++) cycle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16 x 32-bit register file. The register file has a single port and forbids a simultaneous read_en and write_en.
- Accepts one read or write command at a time from requester A or B, using round-robin arbitration.
- Drives the register file's read_en/write_en/addr/write_data with a single command per issue cycle, so the read+write violation can never occur.
- Returns read data to the requester that owns the command, with a valid pulse.

Parameters:
- DATA_W, 32, data width; matches register length.
- ADDR_W, 4, address width; 16 registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A command request; held until a_gnt.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A register address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A command accepted (one-cycle pulse).
- a_rvalid  out  1  A read data valid (one-cycle pulse).
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- rf_read_en  out  1  to register file read_en.
- rf_write_en  out  1  to register file write_en.
- rf_addr  out  ADDR_W  to register file addr.
- rf_write_data  out  DATA_W  to register file write_data.
- rf_read_data  in  DATA_W  from register file read_data. The register file registers this output, so it is valid the cycle after rf_read_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; last_owner = B, so A wins the first contention.
  - All rf_* outputs = 0; latched command cleared.
  - gnt, rvalid and rdata outputs are all 0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, select the winner.
  - If only one req is high, that requester wins.
  - If both are high, the requester that is not last_owner wins.
  - The winner's gnt is high combinationally in this cycle, gated by state==IDLE and rst_n.
  - On the clock edge, latch we/addr/wdata/owner, update last_owner, go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - Registered outputs: rf_addr = latched addr.
  - Write command: rf_write_en = 1, rf_write_data = latched wdata, rf_read_en = 0; next state IDLE.
  - Read command: rf_read_en = 1, rf_write_en = 0; next state RESP.
  - rf_read_en and rf_write_en are never both 1 (invariant, also asserted in simulation).
- RESP:
  - The owner's rvalid = 1 for this one cycle; owner rdata = rf_read_data.
  - The non-owner's rdata = 0. Outside RESP, both rdata outputs = 0.
  - Next state IDLE.
- Strobes: rf_read_en and rf_write_en are high only in ISSUE. In IDLE and RESP they are 0, and rf_addr and rf_write_data hold their last values.
- Latency (gnt at cycle T):
  - Write: rf_write_en at T+1; earliest next gnt at T+2.
  - Read: rf_read_en at T+1; rvalid/rdata at T+2; earliest next gnt at T+3.
- Requester rules:
  - A requester must hold req/we/addr/wdata stable until it sees gnt.
  - Dropping req before gnt withdraws the request; this is legal.
  - Inputs after gnt are ignored until the next IDLE.
  - Requests are not accepted in ISSUE or RESP; req is held, not lost.
- Simultaneous events:
  - A requester may reassert req in the same cycle as its own rvalid; it is arbitrated in the following IDLE cycle.
  - Under continuous contention, grants alternate A, B, A, B.
- Reset mid-operation:
  - An in-flight command is dropped and no rvalid is produced.
  - A write whose ISSUE cycle was aborted by reset is not performed.
  - Register file contents are otherwise untouched.
- Invalid commands: the block cannot generate an invalid command, so no error output exists.

Optional Feature:
- Macro REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins when both req are high, last_owner is unused, and B may starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset then a single write: A writes 0xDEADBEEF to addr 3.
  - a_gnt at T; at T+1 rf_write_en=1, rf_addr=3, rf_write_data=0xDEADBEEF, rf_read_en=0.
  - Next: B reads addr 3 -> b_rvalid=1 with b_rdata=0xDEADBEEF two cycles after b_gnt; a_rvalid stays 0.
- Contention: A and B both hold req for reads of addr 1 and addr 2.
  - Grants in order A, B, A, B; gnt spacing is 3 cycles.
  - Each rvalid goes only to its owner with the correct data.
- Mixed contention: A writes, B reads the same address, both asserted together.
  - A is granted first (write); B's read then returns the new value, proving write-before-read ordering.
- Invariant: 200 random cycles of random req/we/addr on both ports.
  - rf_read_en & rf_write_en never both 1; every accepted read yields exactly one rvalid.
  - A reference model's register contents match.
- Reset mid-read: assert rst_n=0 during ISSUE of a read.
  - All outputs go to 0 immediately with no rvalid afterwards; after release, the first contention grants A.
- With REG_ARB_FIXED_PRIO_EN defined: A and B both hold req continuously.
  - Only A is granted; B is granted as soon as a_req drops.
